// File: rtl/par2ser_pkg.sv
// Shared types and helpers for the parallel-to-serial transmitter.
package par2ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int WIDTH_DEFAULT = 8;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/par2ser_bit_counter.sv
// Bit-position counter for one serial frame; flags the final bit position.
module par2ser_bit_counter
    import par2ser_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          inc,
    output logic [cnt_width(WIDTH)-1:0]   count,
    output logic                          at_last
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0] r_count;

    // clr wins over inc so a back-to-back reload restarts at bit 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count   = r_count;
    assign at_last = (r_count == CW'(WIDTH - 1));

endmodule

// File: rtl/par2ser_tx.sv
// Parallel-to-serial transmitter: valid/ready word load, one bit per enabled cycle,
// first/last frame flags, zero-gap back-to-back frames.
module par2ser_tx
    import par2ser_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             en,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_first,
    output logic             sout_last
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_shreg, w_shreg_nx;
    logic             r_sout, w_sout_nx;
    logic             r_valid, w_valid_nx;
    logic             r_first, w_first_nx;
    logic             r_last, w_last_nx;
    logic [CW-1:0]    w_count;
    logic             w_at_last;
    logic             w_clr;
    logic             w_inc;
    logic             w_accept;

    par2ser_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .inc     (w_inc),
        .count   (w_count),
        .at_last (w_at_last)
    );

    assign load_ready = (r_state == IDLE) | ((r_state == SHIFT) & r_last & en);
    assign w_accept   = load_valid & load_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_sout  <= 1'b0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_shreg <= w_shreg_nx;
            r_sout  <= w_sout_nx;
            r_valid <= w_valid_nx;
            r_first <= w_first_nx;
            r_last  <= w_last_nx;
        end
    end

    // Accept is only possible from IDLE or on the enabled last bit, so it covers both cases
    always_comb begin
        w_state_nx = r_state;
        w_shreg_nx = r_shreg;
        w_sout_nx  = r_sout;
        w_valid_nx = r_valid;
        w_first_nx = r_first;
        w_last_nx  = r_last;
        w_clr      = 1'b0;
        w_inc      = 1'b0;
        if (w_accept) begin
            w_state_nx = SHIFT;
            w_shreg_nx = d;
            w_sout_nx  = MSB_FIRST ? d[WIDTH-1] : d[0];
            w_valid_nx = 1'b1;
            w_first_nx = 1'b1;
            w_last_nx  = 1'b0;
            w_clr      = 1'b1;
        end else if ((r_state == SHIFT) && en) begin
            if (!w_at_last) begin
                if (MSB_FIRST) begin
                    w_shreg_nx = {r_shreg[WIDTH-2:0], 1'b0};
                    w_sout_nx  = r_shreg[WIDTH-2];
                end else begin
                    w_shreg_nx = {1'b0, r_shreg[WIDTH-1:1]};
                    w_sout_nx  = r_shreg[1];
                end
                w_first_nx = 1'b0;
                w_last_nx  = (w_count == CW'(WIDTH - 2));
                w_inc      = 1'b1;
            end else begin
                w_state_nx = IDLE;
                w_shreg_nx = '0;
                w_sout_nx  = 1'b0;
                w_valid_nx = 1'b0;
                w_first_nx = 1'b0;
                w_last_nx  = 1'b0;
                w_clr      = 1'b1;
            end
        end
    end

    assign sout       = r_sout;
    assign sout_valid = r_valid;
    assign sout_first = r_first;
    assign sout_last  = r_last;

endmodule

// File: tb/tb_par2ser_tx.sv
// Directed bench for par2ser_tx: an MSB-first and an LSB-first instance share one stimulus.
module tb_par2ser_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       lv;
    logic       en;
    logic [7:0] d;

    logic rdy_m, sout_m, val_m, fst_m, lst_m;
    logic rdy_l, sout_l, val_l, fst_l, lst_l;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    par2ser_tx #(
        .WIDTH     (8),
        .MSB_FIRST (1'b1)
    ) u_dut_msb (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .load_valid (lv),
        .load_ready (rdy_m),
        .en         (en),
        .sout       (sout_m),
        .sout_valid (val_m),
        .sout_first (fst_m),
        .sout_last  (lst_m)
    );

    par2ser_tx #(
        .WIDTH     (8),
        .MSB_FIRST (1'b0)
    ) u_dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .load_valid (lv),
        .load_ready (rdy_l),
        .en         (en),
        .sout       (sout_l),
        .sout_valid (val_l),
        .sout_first (fst_l),
        .sout_last  (lst_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " m.valid"}, 32'(val_m),  32'd0);
        check({tag, " m.sout"},  32'(sout_m), 32'd0);
        check({tag, " m.first"}, 32'(fst_m),  32'd0);
        check({tag, " m.last"},  32'(lst_m),  32'd0);
        check({tag, " l.valid"}, 32'(val_l),  32'd0);
        check({tag, " l.sout"},  32'(sout_l), 32'd0);
        check({tag, " l.first"}, 32'(fst_l),  32'd0);
        check({tag, " l.last"},  32'(lst_l),  32'd0);
    endtask

    task automatic check_bit(input string tag, input int i, input logic [7:0] w, input bit exp_rdy);
        string t;
        t = $sformatf("%s bit%0d", tag, i);
        check({t, " m.sout"},  32'(sout_m), 32'(w[7-i]));
        check({t, " m.valid"}, 32'(val_m),  32'd1);
        check({t, " m.first"}, 32'(fst_m),  32'(i == 0));
        check({t, " m.last"},  32'(lst_m),  32'(i == 7));
        check({t, " m.ready"}, 32'(rdy_m),  32'(exp_rdy));
        check({t, " l.sout"},  32'(sout_l), 32'(w[i]));
        check({t, " l.valid"}, 32'(val_l),  32'd1);
        check({t, " l.first"}, 32'(fst_l),  32'(i == 0));
        check({t, " l.last"},  32'(lst_l),  32'(i == 7));
        check({t, " l.ready"}, 32'(rdy_l),  32'(exp_rdy));
    endtask

    // Called on the falling edge right after the accept edge; returns on the last bit's falling edge
    task automatic frame_check(input string tag, input logic [7:0] w, input int stall_at);
        for (int i = 0; i < 8; i++) begin
            check_bit(tag, i, w, i == 7);
            if (i == stall_at) begin
                en = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_bit({tag, " stalled"}, i, w, 1'b0);
                end
                en = 1'b1;
            end
            if (i < 7) @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        lv  = 1'b1;
        d   = 8'hAA;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("in_reset");

        rst = 1'b1;
        lv  = 1'b0;
        #1;
        check("post_reset m.ready", 32'(rdy_m), 32'd1);
        check("post_reset l.ready", 32'(rdy_l), 32'd1);
        @(negedge clk);
        check_idle("post_reset");

        d  = 8'hAA;
        lv = 1'b1;
        @(negedge clk);
        lv = 1'b0;
        frame_check("single", 8'hAA, -1);
        @(negedge clk);
        check_idle("single_end");
        check("single_end m.ready", 32'(rdy_m), 32'd1);

        d  = 8'hFF;
        lv = 1'b1;
        check("b2b accept1 m.ready", 32'(rdy_m), 32'd1);
        @(negedge clk);
        d = 8'hA0;
        frame_check("b2b_f1", 8'hFF, -1);
        @(negedge clk);
        lv = 1'b0;
        frame_check("b2b_f2", 8'hA0, -1);
        @(negedge clk);
        check_idle("b2b_end");

        d  = 8'hF0;
        lv = 1'b1;
        @(negedge clk);
        lv = 1'b0;
        frame_check("stall", 8'hF0, 1);
        @(negedge clk);
        check_idle("stall_end");

        d  = 8'h01;
        lv = 1'b1;
        @(negedge clk);
        lv = 1'b0;
        frame_check("order", 8'h01, -1);
        @(negedge clk);
        check_idle("order_end");

        d  = 8'hAA;
        lv = 1'b1;
        @(negedge clk);
        lv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_bit("pre_reset", i, 8'hAA, 1'b0);
            if (i < 3) @(negedge clk);
        end
        rst = 1'b0;
        #1;
        check_idle("mid_reset");
        check("mid_reset m.ready", 32'(rdy_m), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        d   = 8'h0F;
        lv  = 1'b1;
        @(negedge clk);
        lv = 1'b0;
        frame_check("after_reset", 8'h0F, -1);
        @(negedge clk);
        check_idle("after_reset_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
